// File: rtl/logic_reduce_pipe_if.sv
// Valid/ready token bus for logic_reduce_pipe: operand side and result side.
interface logic_reduce_pipe_if #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                in_op;
    logic [WIDTH*CHANNELS-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [CHANNELS-1:0]       out_y;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_y
    );

    // The reduction pipeline itself.
    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/logic_reduce_pipe.sv
// Pipelined per-lane logic reduction (AND/OR/XOR/NAND) over a registered
// binary tree, one combine level per stage, with global-stall valid/ready.
// Optional statistics counters: define LOGIC_REDUCE_STATS_EN.
module logic_reduce_pipe #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned CHANNELS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    logic_reduce_pipe_if.slave  bus
`ifdef LOGIC_REDUCE_STATS_EN
    ,
    output logic [15:0]         acc_cnt,
    output logic [15:0]         emit_cnt,
    output logic [15:0]         ones_cnt
`endif
);

    localparam int unsigned LAT    = $clog2(WIDTH) + 1;
    localparam int unsigned LEVELS = LAT - 1;

    localparam logic [1:0] OP_AND  = 2'd0;
    localparam logic [1:0] OP_OR   = 2'd1;
    localparam logic [1:0] OP_XOR  = 2'd2;
    localparam logic [1:0] OP_NAND = 2'd3;

    // Pairwise combine; NAND shares the AND tree and is inverted at the end.
    function automatic logic combine(input logic [1:0] op, input logic a, input logic b);
        logic r;
        r = a & b;
        case (op)
            OP_AND, OP_NAND: r = a & b;
            OP_OR:           r = a | b;
            OP_XOR:          r = a ^ b;
        endcase
        return r;
    endfunction

    logic             en;
    logic [LAT-1:0]   vld_q;
    logic [1:0]       op_q [LEVELS];

    // Whole pipeline freezes only when a result is held for the consumer.
    assign en           = !(bus.out_valid && !bus.out_ready);
    assign bus.in_ready = en;
    assign bus.out_valid = vld_q[LAT-1];

    // Valid and op shift along with their token; bubbles stay in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < int'(LEVELS); k++) begin
                op_q[k] <= '0;
            end
        end else if (en) begin
            vld_q <= {vld_q[LAT-2:0], bus.in_valid};
            if (bus.in_valid) begin
                op_q[0] <= bus.in_op;
            end
            for (int k = 1; k < int'(LEVELS); k++) begin
                op_q[k] <= op_q[k-1];
            end
        end
    end

    // Level k holds ceil(WIDTH / 2^k) partial results per lane.
    for (genvar k = 0; k < int'(LAT); k++) begin : g_lvl
        localparam int unsigned N = (WIDTH + (32'd1 << k) - 32'd1) >> k;
        logic [CHANNELS-1:0][N-1:0] d;

        if (k == 0) begin : g_in
            // Operand capture, only on an accepted token.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d <= '0;
                end else if (en && bus.in_valid) begin
                    d <= bus.in_data;
                end
            end
        end else begin : g_tree
            localparam int unsigned NP = (WIDTH + (32'd1 << (k-1)) - 32'd1) >> (k-1);
            logic                       inv;
            logic [CHANNELS-1:0][N-1:0] nxt;

            assign inv = (k == int'(LAT) - 1) && (op_q[k-1] == OP_NAND);

            for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_ch
                for (genvar i = 0; i < int'(N); i++) begin : g_el
                    if (2*i + 1 < int'(NP)) begin : g_pair
                        assign nxt[c][i] = combine(op_q[k-1], g_lvl[k-1].d[c][2*i],
                                                   g_lvl[k-1].d[c][2*i+1]) ^ inv;
                    end else begin : g_pass
                        assign nxt[c][i] = g_lvl[k-1].d[c][2*i] ^ inv;
                    end
                end
            end

            // Tree level register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d <= '0;
                end else if (en) begin
                    d <= nxt;
                end
            end
        end
    end

    for (genvar c = 0; c < int'(CHANNELS); c++) begin : g_out
        assign bus.out_y[c] = g_lvl[LAT-1].d[c][0];
    end

`ifdef LOGIC_REDUCE_STATS_EN
    // Saturating handshake counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt  <= '0;
            emit_cnt <= '0;
            ones_cnt <= '0;
        end else begin
            if (bus.in_valid && en && acc_cnt != 16'hFFFF) begin
                acc_cnt <= acc_cnt + 16'd1;
            end
            if (bus.out_valid && bus.out_ready && emit_cnt != 16'hFFFF) begin
                emit_cnt <= emit_cnt + 16'd1;
            end
            if (bus.out_valid && bus.out_ready && (&bus.out_y) && ones_cnt != 16'hFFFF) begin
                ones_cnt <= ones_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_logic_reduce_pipe.sv
// Bench for logic_reduce_pipe: directed latency/op/backpressure/reset cases
// plus randomized traffic, scored against a lane-reduction reference model.
module tb_logic_reduce_pipe;

    localparam int unsigned W    = 8;
    localparam int unsigned C    = 2;
    localparam int unsigned W5   = 5;
    localparam int unsigned C5   = 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic_reduce_pipe_if #(.WIDTH(W),  .CHANNELS(C))  bus  ();
    logic_reduce_pipe_if #(.WIDTH(W5), .CHANNELS(C5)) bus5 ();

`ifdef LOGIC_REDUCE_STATS_EN
    logic [15:0] acc_cnt, emit_cnt, ones_cnt;
    logic [15:0] acc5, emit5, ones5;
`endif

    logic_reduce_pipe #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LOGIC_REDUCE_STATS_EN
        ,
        .acc_cnt  (acc_cnt),
        .emit_cnt (emit_cnt),
        .ones_cnt (ones_cnt)
`endif
    );

    logic_reduce_pipe #(.WIDTH(W5), .CHANNELS(C5)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
`ifdef LOGIC_REDUCE_STATS_EN
        ,
        .acc_cnt  (acc5),
        .emit_cnt (emit5),
        .ones_cnt (ones5)
`endif
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: reduce every lane with the operator named by op.
    function automatic logic [C-1:0] ref_y(input logic [1:0] op, input logic [W*C-1:0] d);
        logic [C-1:0] r;
        logic [W-1:0] lane;
        r = '0;
        for (int c = 0; c < int'(C); c++) begin
            lane = d[c*W +: W];
            case (op)
                2'd0:    r[c] = &lane;
                2'd1:    r[c] = |lane;
                2'd2:    r[c] = ^lane;
                default: r[c] = ~&lane;
            endcase
        end
        return r;
    endfunction

    function automatic logic ref_y5(input logic [1:0] op, input logic [W5-1:0] d);
        case (op)
            2'd0:    return &d;
            2'd1:    return |d;
            2'd2:    return ^d;
            default: return ~&d;
        endcase
    endfunction

    // Lanes biased towards all-ones / all-zeros / one-hole so AND/OR see both results.
    function automatic logic [W-1:0] rand_lane();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            2:       return ~(W'(1) << $urandom_range(0, W-1));
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [W5-1:0] rand_lane5();
        case ($urandom_range(0, 3))
            0:       return '1;
            1:       return '0;
            2:       return W5'(1) << $urandom_range(0, W5-1);
            default: return W5'($urandom);
        endcase
    endfunction

    logic [C-1:0] sb_q [$];
    logic         sb5_q [$];
    int unsigned  n_out = 0;
    bit           was_stall = 1'b0;
    logic [C-1:0] held_y = '0;

    // Scoreboard and protocol monitor for the 8-bit, 2-lane instance.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("in_ready_rule", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
            if (was_stall) begin
                check_eq("hold_valid", 64'(bus.out_valid), 64'd1);
                check_eq("hold_y", 64'(bus.out_y), 64'(held_y));
            end
            was_stall = bus.out_valid && !bus.out_ready;
            held_y    = bus.out_y;
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(ref_y(bus.in_op, bus.in_data));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sb_q.size() == 0) check_eq("spurious_out", 64'd1, 64'd0);
                else                  check_eq("out_y", 64'(bus.out_y), 64'(sb_q.pop_front()));
            end
        end
    end

    // Scoreboard for the 5-bit instance (always ready downstream).
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus5.in_valid && bus5.in_ready) begin
                sb5_q.push_back(ref_y5(bus5.in_op, bus5.in_data));
            end
            if (bus5.out_valid) begin
                if (sb5_q.size() == 0) check_eq("w5_spurious_out", 64'd1, 64'd0);
                else                   check_eq("w5_out_y", 64'(bus5.out_y), 64'(sb5_q.pop_front()));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W*C-1:0] tok [6];
        logic [3:0]     seq;
        int             sent;
        int unsigned    base;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_op      = '0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        bus5.in_valid  = 1'b0;
        bus5.in_op     = '0;
        bus5.in_data   = '0;
        bus5.out_ready = 1'b1;

        // Reset state.
        #12;
        check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_eq("rst_out_y", 64'(bus.out_y), 64'd0);
        check_eq("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check_eq("rst_w5_out_valid", 64'(bus5.out_valid), 64'd0);
        #10;
        rst_n = 1'b1;
        step();

        // Latency: single token, result valid for exactly one cycle after edge t+3.
        bus.in_valid = 1'b1;
        bus.in_op    = 2'd0;
        bus.in_data  = 16'hFFFE;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check_eq("lat_out_valid", 64'(bus.out_valid), (i == 3) ? 64'd1 : 64'd0);
            if (i == 3) check_eq("lat_out_y", 64'(bus.out_y), 64'b10);
            step();
        end

        // Op coverage: lane0 = A5 under AND, OR, XOR, NAND back to back.
        seq = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid           = 1'b1;
            bus.in_op              = 2'(i);
            bus.in_data[W-1:0]     = W'(8'hA5);
            bus.in_data[2*W-1:W]   = rand_lane();
            step();
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("opcov_valid", 64'(bus.out_valid), 64'd1);
            check_eq("opcov_y0", 64'(bus.out_y[0]), 64'(seq[i]));
            step();
        end
        check_eq("opcov_after", 64'(bus.out_valid), 64'd0);

        // Backpressure: six tokens, consumer stalls for cycles 5..9.
        for (int i = 0; i < 6; i++) tok[i] = {rand_lane(), rand_lane()};
        sent = 0;
        base = n_out;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bus.out_ready = !(cyc >= 5 && cyc <= 9);
            bus.in_valid  = (sent < 6);
            bus.in_op     = 2'(sent % 4);
            bus.in_data   = tok[sent % 6];
            #1;
            if (cyc >= 5 && cyc <= 9) check_eq("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            if (bus.in_valid && bus.in_ready) sent++;
            step();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check_eq("bp_sent", 64'(sent), 64'd6);
        check_eq("bp_consumed", 64'(n_out - base), 64'd6);
        check_eq("bp_sb_empty", 64'(sb_q.size()), 64'd0);

        // Odd width: 5'b10000 XOR -> 1, 5'b11111 AND -> 1.
        bus5.in_valid = 1'b1;
        bus5.in_op    = 2'd2;
        bus5.in_data  = 5'b10000;
        step();
        bus5.in_op    = 2'd0;
        bus5.in_data  = 5'b11111;
        step();
        bus5.in_valid = 1'b0;
        check_eq("w5_lat_early1", 64'(bus5.out_valid), 64'd0);
        step();
        check_eq("w5_lat_early2", 64'(bus5.out_valid), 64'd0);
        step();
        check_eq("w5_xor_valid", 64'(bus5.out_valid), 64'd1);
        check_eq("w5_xor_y", 64'(bus5.out_y), 64'd1);
        step();
        check_eq("w5_and_valid", 64'(bus5.out_valid), 64'd1);
        check_eq("w5_and_y", 64'(bus5.out_y), 64'd1);
        step();
        check_eq("w5_done", 64'(bus5.out_valid), 64'd0);

        // Mid-flight reset: three tokens in flight, async pulse between edges.
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_op    = 2'($urandom);
            bus.in_data  = {rand_lane(), rand_lane()};
            step();
        end
        bus.in_valid = 1'b0;
        step();
        check_eq("mr_pre_valid", 64'(bus.out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("mr_async_valid", 64'(bus.out_valid), 64'd0);
        check_eq("mr_async_in_ready", 64'(bus.in_ready), 64'd1);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        sb5_q.delete();
        was_stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq("mr_no_output", 64'(bus.out_valid), 64'd0);
        end

        // Randomized traffic on both instances with random backpressure on the 8-bit one.
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_op     = 2'($urandom);
            for (int c = 0; c < int'(C); c++) bus.in_data[c*W +: W] = rand_lane();
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus5.in_valid = ($urandom_range(0, 1) != 0);
            bus5.in_op    = 2'($urandom);
            bus5.in_data  = rand_lane5();
            step();
        end
        bus.in_valid  = 1'b0;
        bus5.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check_eq("rand_sb_empty", 64'(sb_q.size()), 64'd0);
        check_eq("rand_w5_sb_empty", 64'(sb5_q.size()), 64'd0);

`ifdef LOGIC_REDUCE_STATS_EN
        // Counter saturation with all-ones AND tokens.
        bus.in_valid = 1'b1;
        bus.in_op    = 2'd0;
        bus.in_data  = '1;
        for (int i = 0; i < 70000; i++) step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check_eq("stat_acc_sat", 64'(acc_cnt), 64'hFFFF);
        check_eq("stat_emit_sat", 64'(emit_cnt), 64'hFFFF);
        check_eq("stat_ones_sat", 64'(ones_cnt), 64'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
